// File: rtl/gray_burst_pkg.sv
// Shared types and helpers for the Gray-code burst arbiter.
// Optional counter-clear input is enabled by defining GRAY_ARB_CLR_EN.
package gray_burst_pkg;

    localparam int GBA_NREQ  = 2;
    localparam int GBA_WIDTH = 4;
    localparam int GBA_LEN_W = 4;
    localparam int OWN_W     = $clog2(GBA_NREQ);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} gba_state_t;

    // Binary-to-Gray: each Gray bit is the XOR of two neighbouring binary bits.
    function automatic logic [GBA_WIDTH-1:0] bin2gray(input logic [GBA_WIDTH-1:0] b);
        return {b[GBA_WIDTH-1], b[GBA_WIDTH-1:1] ^ b[GBA_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/gba_rr_pick.sv
// Combinational round-robin picker: first valid request at or above the
// rotating pointer, wrapping modulo NREQ. Part of the GRAY_ARB_CLR_EN-aware arbiter.
module gba_rr_pick
    import gray_burst_pkg::*;
#(
    parameter int NREQ   = GBA_NREQ,
    parameter int OWN_BITS = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]     i_req_valid,
    input  logic [OWN_BITS-1:0] i_rr_ptr,
    output logic [NREQ-1:0]     o_grant,
    output logic [OWN_BITS-1:0] o_idx,
    output logic                o_any
);

    // Scan NREQ positions starting at the pointer; the first hit wins.
    always_comb begin
        int j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(i_rr_ptr) + k) % NREQ;
            if (!o_any && i_req_valid[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = OWN_BITS'(j);
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/gray_burst_arbiter.sv
// Round-robin arbiter sharing one persistent binary-backed Gray counter between
// requesters in bursts. Define GRAY_ARB_CLR_EN to add the cnt_clr input.
module gray_burst_arbiter
    import gray_burst_pkg::*;
#(
    parameter int NREQ  = GBA_NREQ,
    parameter int WIDTH = GBA_WIDTH,
    parameter int LEN_W = GBA_LEN_W
) (
    input  logic                  clk,
    input  logic                  rstn,
`ifdef GRAY_ARB_CLR_EN
    input  logic                  cnt_clr,
`endif
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  hold,
    output logic                  step_valid,
    output logic [WIDTH-1:0]      step_gray,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] step_owner,
    output logic                  step_last,
    output logic                  busy
);

    localparam int OWN_BITS = (NREQ > 1) ? $clog2(NREQ) : 1;

    gba_state_t          r_state;
    logic [WIDTH-1:0]    r_count;
    logic [LEN_W-1:0]    r_remaining;
    logic [OWN_BITS-1:0] r_owner;
    logic [OWN_BITS-1:0] r_rr_ptr;

    logic [NREQ-1:0]     w_grant;
    logic [OWN_BITS-1:0] w_idx;
    logic                w_any;
    logic                w_clr;
    logic                w_accept;
    logic                w_step;
    logic [OWN_BITS-1:0] w_next_ptr;

`ifdef GRAY_ARB_CLR_EN
    assign w_clr = cnt_clr;
`else
    assign w_clr = 1'b0;
`endif

    gba_rr_pick #(
        .NREQ     (NREQ),
        .OWN_BITS (OWN_BITS)
    ) u_pick (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_idx       (w_idx),
        .o_any       (w_any)
    );

    // Accept/step qualifiers; every output is forced to zero while rstn is low.
    always_comb begin
        w_accept   = rstn && (r_state == IDLE) && w_any && !w_clr;
        w_step     = rstn && (r_state == RUN) && !hold;
        w_next_ptr = (w_idx == OWN_BITS'(NREQ - 1)) ? '0 : w_idx + OWN_BITS'(1);
        req_ready  = w_accept ? w_grant : '0;
        step_valid = w_step;
        step_last  = w_step && (r_remaining == '0);
        busy       = rstn && (r_state == RUN);
        if (rstn) begin
            step_gray  = bin2gray(r_count);
            step_owner = r_owner;
        end else begin
            step_gray  = '0;
            step_owner = '0;
        end
    end

    // Burst FSM, persistent counter and remaining-length bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_remaining <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_clr) begin
                        r_count <= '0;
                    end else if (w_any) begin
                        r_owner     <= w_idx;
                        r_remaining <= req_len[w_idx*LEN_W +: LEN_W];
                        r_rr_ptr    <= w_next_ptr;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    // Hold freezes count, remaining and state alike.
                    if (!hold) begin
                        r_count <= r_count + WIDTH'(1);
                        if (r_remaining == '0) begin
                            r_state <= IDLE;
                        end else begin
                            r_remaining <= r_remaining - LEN_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_burst_arbiter.sv
// Directed self-checking bench for gray_burst_arbiter (GRAY_ARB_CLR_EN optional).
module tb_gray_burst_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] req_valid;
    logic [7:0] req_len;
    logic [1:0] req_ready;
    logic       hold;
    logic       step_valid;
    logic [3:0] step_gray;
    logic [0:0] step_owner;
    logic       step_last;
    logic       busy;
`ifdef GRAY_ARB_CLR_EN
    logic       cnt_clr;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_cnt;
    logic [3:0] seen[$];

    always #5 clk = ~clk;

    gray_burst_arbiter dut (
        .clk        (clk),
        .rstn       (rstn),
`ifdef GRAY_ARB_CLR_EN
        .cnt_clr    (cnt_clr),
`endif
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .hold       (hold),
        .step_valid (step_valid),
        .step_gray  (step_gray),
        .step_owner (step_owner),
        .step_last  (step_last),
        .busy       (busy)
    );

    function automatic logic [3:0] g_of(input logic [3:0] c);
        return c ^ (c >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One accept cycle then len+1 steps; optional hold stretch before step hold_step.
    task automatic do_burst(input int who, input logic [1:0] v_acc, input logic [1:0] v_run,
                            input int len, input int hold_step, input int hold_n, input string tag);
        logic [1:0] exp_rdy;
        exp_rdy      = 2'b00;
        exp_rdy[who] = 1'b1;
        seen.delete();
        @(negedge clk);
        rstn = 1'b1;
`ifdef GRAY_ARB_CLR_EN
        cnt_clr = 1'b0;
`endif
        req_valid = v_acc;
        req_len[who*4 +: 4] = 4'(len);
        #1;
        chk({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        for (int s = 0; s <= len; s++) begin
            @(negedge clk);
            req_valid = v_run;
            if (s == hold_step) begin
                for (int h = 0; h < hold_n; h++) begin
                    hold = 1'b1;
                    #1;
                    chk({tag, "_hold_v"}, 32'(step_valid), 32'd0);
                    chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
                    @(negedge clk);
                end
                hold = 1'b0;
            end
            #1;
            chk({tag, "_valid"}, 32'(step_valid), 32'd1);
            chk({tag, "_gray"}, 32'(step_gray), 32'(g_of(exp_cnt)));
            chk({tag, "_owner"}, 32'(step_owner), 32'(who));
            chk({tag, "_last"}, 32'(step_last), 32'(s == len));
            chk({tag, "_rdy_run"}, 32'(req_ready), 32'd0);
            seen.push_back(step_gray);
            exp_cnt = exp_cnt + 4'd1;
        end
    endtask

    initial begin
        logic [3:0] exp2 [4];
        logic [3:0] exp5 [4];
        exp2 = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
        exp5 = '{4'b1001, 4'b1000, 4'b0000, 4'b0001};
        rstn      = 1'b0;
        req_valid = 2'b11;
        req_len   = 8'h00;
        hold      = 1'b0;
`ifdef GRAY_ARB_CLR_EN
        cnt_clr   = 1'b0;
`endif
        exp_cnt   = 4'd0;

        // Test 1: outputs held at zero during reset even with both requests up.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("t1_rdy", 32'(req_ready), 32'd0);
            chk("t1_valid", 32'(step_valid), 32'd0);
            chk("t1_last", 32'(step_last), 32'd0);
            chk("t1_busy", 32'(busy), 32'd0);
            chk("t1_gray", 32'(step_gray), 32'd0);
            chk("t1_owner", 32'(step_owner), 32'd0);
        end

        // Test 2: r0 wins first after reset, len=3 -> Gray 0,1,3,2.
        do_burst(0, 2'b11, 2'b00, 3, -1, 0, "t2");
        chk("t2_count", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) chk("t2_seq", 32'(seen[i]), 32'(exp2[i]));
        end
        @(negedge clk);
        #1;
        chk("t2_busy_drop", 32'(busy), 32'd0);

        // Test 3: both always requesting; pointer now favours r1, so r1,r0,r1,r0.
        for (int b = 0; b < 4; b++) begin
            do_burst((b % 2 == 0) ? 1 : 0, 2'b11, 2'b11, 1, -1, 0, "t3");
        end

        // Test 4: len=2 burst, hold 3 cycles before its 2nd step.
        do_burst(1, 2'b10, 2'b00, 2, 1, 3, "t4");
        chk("t4_steps", 32'(seen.size()), 32'd3);

        // Test 5: advance counter 0xF -> 0xE, then a wrapping len=3 burst.
        do_burst(0, 2'b01, 2'b00, 14, -1, 0, "t5a");
        chk("t5_pre", 32'(exp_cnt), 32'hE);
        do_burst(1, 2'b10, 2'b00, 3, -1, 0, "t5");
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) chk("t5_wrap", 32'(seen[i]), 32'(exp5[i]));
        end

        // Mid-burst reset: two steps of a len=5 burst, then rstn low.
        @(negedge clk);
        req_valid   = 2'b01;
        req_len[3:0] = 4'd5;
        #1;
        chk("t5r_rdy", 32'(req_ready), 32'd1);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            chk("t5r_gray", 32'(step_gray), 32'(g_of(exp_cnt)));
            exp_cnt = exp_cnt + 4'd1;
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("t5r_busy_rst", 32'(busy), 32'd0);
        chk("t5r_valid_rst", 32'(step_valid), 32'd0);
        exp_cnt = 4'd0;
        do_burst(0, 2'b11, 2'b00, 0, -1, 0, "t5r");
        chk("t5r_gray0", 32'(seen[0]), 32'd0);

`ifdef GRAY_ARB_CLR_EN
        // Test 6: clear in IDLE blocks the accept; next burst starts at Gray 0.
        @(negedge clk);
        req_valid = 2'b10;
        cnt_clr   = 1'b1;
        #1;
        chk("t6_blocked", 32'(req_ready), 32'd0);
        exp_cnt = 4'd0;
        do_burst(1, 2'b10, 2'b00, 0, -1, 0, "t6");
        chk("t6_gray0", 32'(seen[0]), 32'd0);
`endif

        @(negedge clk);
        #1;
        chk("end_idle", 32'(busy), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
